// File: rtl/unsigned7x7_pp_reducer_pkg.sv
// unsigned7x7_pp_reducer_pkg: shared widths and alignment shifts for the unsigned 7x7 multiplier path
package unsigned7x7_pp_reducer_pkg;
  localparam int PP00_W  = 11;
  localparam int PP01_W  = 12;
  localparam int PP02_W  = 12;
  localparam int PP03_W  = 10;
  localparam int PROD7_W = 14;
  localparam int PP02_SH = 2;
  localparam int PP03_SH = 4;
  typedef logic [PROD7_W-1:0] prod_t;
endpackage

// File: rtl/unsigned7x7_pp_reducer_if.sv
// unsigned7x7_pp_reducer_if: partial-product input and product output handshake bundle
interface unsigned7x7_pp_reducer_if import unsigned7x7_pp_reducer_pkg::*; #(parameter int TAG_W = 4);
  logic              in_valid;
  logic              in_ready;
  logic [PP00_W-1:0] pp00;
  logic [PP01_W-1:0] pp01;
  logic [PP02_W-1:0] pp02;
  logic [PP03_W-1:0] pp03;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  prod_t             product;
  logic [TAG_W-1:0]  out_tag;
  modport master (output in_valid, pp00, pp01, pp02, pp03, in_tag, out_ready,
                  input  in_ready, out_valid, product, out_tag);
  modport slave  (input  in_valid, pp00, pp01, pp02, pp03, in_tag, out_ready,
                  output in_ready, out_valid, product, out_tag);
endinterface

// File: rtl/unsigned7x7_pp_stage.sv
// unsigned7x7_pp_stage: valid/data register slice that loads on load and otherwise holds
module unsigned7x7_pp_stage #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;
  always_comb begin
    valid_d = load ? in_valid : valid_q;
    data_d  = load ? d : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign q     = data_q;
endmodule

// File: rtl/unsigned7x7_pp_reducer.sv
// unsigned7x7_pp_reducer: two-stage pipelined sum of aligned partial products mod 2^14
module unsigned7x7_pp_reducer import unsigned7x7_pp_reducer_pkg::*; #(parameter int TAG_W = 4) (
  input logic                     clk,
  input logic                     rst_n,
  unsigned7x7_pp_reducer_if.slave bus
);
  localparam int SA_W = PP01_W + 1;
  typedef struct packed {
    logic [SA_W-1:0]  sa;
    prod_t            sb;
    logic [TAG_W-1:0] tag;
  } s1_t;
  typedef struct packed {
    prod_t            prod;
    logic [TAG_W-1:0] tag;
  } s2_t;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic v1, v2, s1_load, s2_load;
  // carries past bit 13 are dropped; the sign-extension constants rely on this wrap
  always_comb begin
    s2_load  = !v2 || bus.out_ready;
    s1_load  = !v1 || s2_load;
    s1_d.sa  = SA_W'(bus.pp00) + SA_W'(bus.pp01);
    s1_d.sb  = (PROD7_W'(bus.pp02) << PP02_SH) + (PROD7_W'(bus.pp03) << PP03_SH);
    s1_d.tag = bus.in_tag;
    s2_d.prod = PROD7_W'(s1_q.sa) + s1_q.sb;
    s2_d.tag  = s1_q.tag;
  end
  unsigned7x7_pp_stage #(.W($bits(s1_t))) u_s1 (
    .clk(clk), .rst_n(rst_n), .load(s1_load), .in_valid(bus.in_valid),
    .d(s1_d), .valid(v1), .q(s1_q)
  );
  unsigned7x7_pp_stage #(.W($bits(s2_t))) u_s2 (
    .clk(clk), .rst_n(rst_n), .load(s2_load), .in_valid(v1),
    .d(s2_d), .valid(v2), .q(s2_q)
  );
  assign bus.in_ready  = !v1 || !v2 || bus.out_ready;
  assign bus.out_valid = v2;
  assign bus.product   = s2_q.prod;
  assign bus.out_tag   = s2_q.tag;
endmodule

// File: tb/tb_unsigned7x7_pp_reducer.sv
// tb_unsigned7x7_pp_reducer: random and directed checks against an arithmetic scoreboard model
module tb_unsigned7x7_pp_reducer;
  localparam int TAG_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  unsigned7x7_pp_reducer_if #(.TAG_W(TAG_W)) bus();
  unsigned7x7_pp_reducer #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int prod; int tag; int cyc;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_bad = 0, cyc = 0, n_out = 0, n0;
  int last_prod, last_tag, held_prod, held_tag, ra, rb, rc, rd;
  bit chk_lat = 0, hold = 0, saw_block = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic int ref_prod(input int a, input int b, input int c, input int d);
    return (a + b + 4 * c + 16 * d) % 16384;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) hold = 0;
    else begin
      if (hold) begin
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_prod", 32'(bus.product), held_prod);
        chk("hold_tag", 32'(bus.out_tag), held_tag);
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{ref_prod(int'(bus.pp00), int'(bus.pp01), int'(bus.pp02), int'(bus.pp03)),
                       int'(bus.in_tag), cyc});
      if (bus.out_valid) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("prod", 32'(bus.product), sb[0].prod);
          chk("tag", 32'(bus.out_tag), sb[0].tag);
          if (chk_lat && !hold) chk("latency", cyc - sb[0].cyc, 2);
          if (bus.out_ready) begin
            last_prod = int'(bus.product);
            last_tag  = int'(bus.out_tag);
            n_out++;
            void'(sb.pop_front());
          end
        end
      end
      hold      = bus.out_valid && !bus.out_ready;
      held_prod = int'(bus.product);
      held_tag  = int'(bus.out_tag);
      if (!bus.in_ready) saw_block = 1;
    end
  end

  task automatic send(input int a, input int b, input int c, input int d, input int t);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.pp00 = 11'(a); bus.pp01 = 12'(b); bus.pp02 = 12'(c); bus.pp03 = 10'(d);
    bus.in_tag = TAG_W'(t);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input int t);
    send(int'($urandom_range(0, 2047)), int'($urandom_range(0, 4095)),
         int'($urandom_range(0, 4095)), int'($urandom_range(0, 1023)), t);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.pp00 = 0; bus.pp01 = 0; bus.pp02 = 0; bus.pp03 = 0;
    bus.in_tag = 0; bus.out_ready = 1;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_product", 32'(bus.product), 0);
    chk("rst_out_tag", 32'(bus.out_tag), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    chk_lat = 1;
    send(11'h400, 12'hC00, 12'hC00, 0, 5); drain();
    chk("zero_prod", last_prod, 14'h0000);
    chk("zero_tag", last_tag, 5);
    send(1, 0, 0, 0, 1); drain();
    chk("unit_prod", last_prod, 14'h0001);
    send(0, 0, 0, 10'h3FF, 2); drain();
    chk("top_prod", last_prod, 14'h3FF0);
    send(11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF, 3); drain();
    chk("wrap_prod", last_prod, 14'h17EA);
    chk_lat = 0;
    n0 = n_out; saw_block = 0;
    fork
      for (int t = 1; t <= 6; t++) send_rand(t);
      begin
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (bus.out_valid) begin got = 1; break; end
        end
        chk("bp_first_out", 32'(got), 1);
        bus.out_ready = 0;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(bus.in_ready), 0);
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 6);
    chk("bp_saw_block", 32'(saw_block), 1);
    chk_lat = 1;
    n0 = n_out;
    for (int t = 0; t < 20; t++) send_rand(t);
    drain();
    chk("tp_count", n_out - n0, 20);
    chk_lat = 0;
    bus.out_ready = 0;
    send(11'h123, 12'h456, 12'h089, 10'h155, 7);
    send(11'h0F0, 12'h0F0, 12'h0F0, 10'h0F0, 8);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_product", 32'(bus.product), 0);
    chk("mid_rst_out_tag", 32'(bus.out_tag), 0);
    sb.delete();
    @(posedge clk); #3 rst_n = 1;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.out_ready = 1;
    chk_lat = 1;
    n0 = n_out;
    ra = 11'h2AB; rb = 12'h3CD; rc = 12'h0EF; rd = 10'h012;
    send(ra, rb, rc, rd, 9); drain();
    chk("post_rst_count", n_out - n0, 1);
    chk("post_rst_prod", last_prod, ref_prod(ra, rb, rc, rd));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
